hub_lza_normalizer: RTL

Pipelined normalization stage that consumes the leading-zero prediction produced by the LZA alongside the raw HUB mantissa sum from the adder datapath. It applies the predicted left shift, fixes the LZA's ±1 anticipation error and adjusts the exponent. It also flags zero and underflow results before rounding/packing. It sits between the effective-subtraction adder/LZA pair and the result packer, and has a valid/ready handshake on both sides.

---
 rtl/hub_lza_normalizer_if.sv | 33 +++
 rtl/hub_lza_normalizer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/hub_lza_normalizer_if.sv
// Handshake bundle between the adder/LZA stage, the normalizer and the packer.
//   in_*  : unnormalized mantissa, LZA shift prediction, pre-normalization exponent
//   out_* : normalized mantissa, adjusted exponent, zero/underflow/LZA-error flags
// master: the side driving the inputs and out_ready (upstream plus downstream combined).
// slave : the normalizer itself.
interface hub_lza_normalizer_if #(
   parameter int M           = 23,
   parameter int EW          = 8,
   parameter int SHIFT_WIDTH = $clog2(M + 2)
);
   logic                   in_valid;
   logic                   in_ready;
   logic [M+1:0]           in_mant;
   logic [SHIFT_WIDTH-1:0] in_shift;
   logic [EW-1:0]          in_exp;
   logic                   out_valid;
   logic                   out_ready;
   logic [M+1:0]           out_mant;
   logic [EW-1:0]          out_exp;
   logic                   out_zero;
   logic                   out_uf;
   logic                   out_lza_err;

   modport master (
      output in_valid, in_mant, in_shift, in_exp, out_ready,
      input  in_ready, out_valid, out_mant, out_exp, out_zero, out_uf, out_lza_err
   );

   modport slave (
      input  in_valid, in_mant, in_shift, in_exp, out_ready,
      output in_ready, out_valid, out_mant, out_exp, out_zero, out_uf, out_lza_err
   );
endinterface

// File: rtl/hub_lza_normalizer.sv
// Two-stage HUB mantissa normalizer fed by the LZA.
//   Stage 1 applies the predicted left shift (coarse); stage 2 corrects the
//   LZA's +/-1 anticipation error, adjusts the exponent and flags zero,
//   underflow and predictions that were off by more than one position.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : hub_lza_normalizer_if.slave (valid/ready in and out)
// Up to two beats are held (stage-1 register and output register); in_ready
// is combinational from out_ready.
module hub_lza_normalizer #(
   parameter int M           = 23,
   parameter int EW          = 8,
   parameter int SHIFT_WIDTH = $clog2(M + 2)
) (
   input  logic                  clk,
   input  logic                  rst,
   hub_lza_normalizer_if.slave   bus
);
   localparam int DW = M + 2;
   localparam int WW = M + 3;
   // wide enough that nothing falls off during the shift, so lost bits can be seen
   localparam int XW = WW + (1 << SHIFT_WIDTH) - 1;
   localparam int TW = SHIFT_WIDTH + 1;

   logic                   s1_valid;
   logic [WW-1:0]          s1_win;
   logic [EW-1:0]          s1_exp;
   logic [SHIFT_WIDTH-1:0] s1_shift;
   logic                   s1_zero;
   logic                   s1_err;

   logic s2_adv;
   logic s1_adv;

   assign s2_adv      = ~bus.out_valid | bus.out_ready;
   assign s1_adv      = ~s1_valid | s2_adv;
   assign bus.in_ready = s1_adv;

   // stage 1: coarse shift
   logic [XW-1:0] wide_shifted;
   logic [WW-1:0] win_n;
   logic          err1_n;
   logic          zero1_n;

   assign wide_shifted = {{(XW-DW){1'b0}}, bus.in_mant} << bus.in_shift;
   assign win_n        = wide_shifted[WW-1:0];
   assign err1_n       = |wide_shifted[XW-1:WW];
   assign zero1_n      = ~|bus.in_mant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_win   <= '0;
         s1_exp   <= '0;
         s1_shift <= '0;
         s1_zero  <= 1'b0;
         s1_err   <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_win   <= win_n;
            s1_exp   <= bus.in_exp;
            s1_shift <= bus.in_shift;
            s1_zero  <= zero1_n;
            s1_err   <= err1_n;
         end
      end
   end

   // stage 2: fine correction and exponent adjust
   logic [DW-1:0] fine_mant;
   logic [TW-1:0] total;
   logic          fine_err;
   logic [EW:0]   e_diff;
   logic          uf_n;
   logic [DW-1:0] mant_n;
   logic [EW-1:0] exp_n;
   logic          lza_err_n;

   always_comb begin
      fine_mant = s1_win[DW-1:0];
      total     = {1'b0, s1_shift};
      fine_err  = s1_err;
      if (s1_win[WW-1]) begin
         fine_mant = s1_win[WW-1:1];
         total     = {1'b0, s1_shift} - TW'(1);
      end else if (s1_win[DW-1]) begin
         fine_mant = s1_win[DW-1:0];
      end else if (s1_win[M]) begin
         fine_mant = {s1_win[M:0], 1'b0};
         total     = {1'b0, s1_shift} + TW'(1);
      end else begin
         fine_err  = 1'b1;
      end
   end

   // EW+1-bit two's complement difference: MSB set means negative
   assign e_diff = {1'b0, s1_exp} - (EW+1)'(total);
   assign uf_n   = e_diff[EW] | (e_diff == '0);

   always_comb begin
      mant_n    = fine_mant;
      exp_n     = e_diff[EW-1:0];
      lza_err_n = fine_err;
      if (s1_zero) begin
         mant_n    = '0;
         exp_n     = '0;
         lza_err_n = 1'b0;
      end else if (uf_n) begin
         mant_n    = '0;
         exp_n     = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid   <= 1'b0;
         bus.out_mant    <= '0;
         bus.out_exp     <= '0;
         bus.out_zero    <= 1'b0;
         bus.out_uf      <= 1'b0;
         bus.out_lza_err <= 1'b0;
      end else if (s2_adv) begin
         bus.out_valid <= s1_valid;
         if (s1_valid) begin
            bus.out_mant    <= mant_n;
            bus.out_exp     <= exp_n;
            bus.out_zero    <= s1_zero;
            bus.out_uf      <= uf_n & ~s1_zero;
            bus.out_lza_err <= lza_err_n;
         end
      end
   end
endmodule
